addr_unit: RTL

//   Parametrised bank of NUM_PTR split address registers (lo/hi byte pairs) for the 2A03 datapath,

---
 rtl/addr_unit_pkg.sv | 19 +
 rtl/addr_ptr.sv | 49 ++++
 rtl/addr_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/addr_unit_pkg.sv
// Shared encodings for the address unit: op codes and FSM states.
package addr_unit_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP     = 3'd0;
    localparam op_t OP_LDL     = 3'd1;
    localparam op_t OP_LDH     = 3'd2;
    localparam op_t OP_LDW     = 3'd3;
    localparam op_t OP_INC     = 3'd4;
    localparam op_t OP_ADD_IDX = 3'd5;
    localparam op_t OP_ADD_REL = 3'd6;

    typedef enum logic {
        ST_IDLE,
        ST_FIXUP
    } state_t;

endpackage

// File: rtl/addr_ptr.sv
// One lo/hi pointer pair with load, 16-bit increment, low-byte add and high-byte fixup.
module addr_ptr #(
    parameter int                    DATA_W  = 8,
    parameter logic [2*DATA_W-1:0]   RST_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_lo,
    input  logic                  ld_hi,
    input  logic [DATA_W-1:0]     lo_data,
    input  logic [DATA_W-1:0]     hi_data,
    input  logic                  inc,
    input  logic                  add,
    input  logic [DATA_W-1:0]     idx,
    input  logic                  fix,
    input  logic                  fix_dec,
    output logic                  carry,
    output logic [2*DATA_W-1:0]   val
);

    logic [DATA_W-1:0]   lo_reg;
    logic [DATA_W-1:0]   hi_reg;
    logic [DATA_W-1:0]   add_sum_next;
    logic [2*DATA_W-1:0] inc_val_next;

    // Carry out of the low-byte add; the top interprets it as a borrow for negative offsets.
    always_comb begin
        {carry, add_sum_next} = {1'b0, lo_reg} + {1'b0, idx};
        inc_val_next          = {hi_reg, lo_reg} + (2*DATA_W)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {hi_reg, lo_reg} <= RST_VAL;
        end else if (fix) begin
            hi_reg <= fix_dec ? hi_reg - DATA_W'(1) : hi_reg + DATA_W'(1);
        end else if (inc) begin
            {hi_reg, lo_reg} <= inc_val_next;
        end else if (add) begin
            lo_reg <= add_sum_next;
        end else begin
            if (ld_lo) lo_reg <= lo_data;
            if (ld_hi) hi_reg <= hi_data;
        end
    end

    assign val = {hi_reg, lo_reg};

endmodule

// File: rtl/addr_unit.sv
// Bank of split address pointers with indexed/relative add and a one-cycle page-cross fixup stall.
module addr_unit
    import addr_unit_pkg::*;
#(
    parameter int                  DATA_W  = 8,
    parameter int                  NUM_PTR = 3,
    parameter logic [2*DATA_W-1:0] RST_VAL = '0,
    localparam int                 SEL_W   = (NUM_PTR > 1) ? $clog2(NUM_PTR) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op,
    input  logic [SEL_W-1:0]      sel,
    input  logic [2*DATA_W-1:0]   din,
    input  logic [DATA_W-1:0]     idx,
    input  logic [SEL_W-1:0]      addr_sel,
    output logic [2*DATA_W-1:0]   addr_out,
    output logic                  page_cross
);

    state_t              state_reg;
    logic                op_ready_reg;
    logic                page_cross_reg;
    logic [SEL_W-1:0]    fix_sel_reg;
    logic                fix_dec_reg;

    logic                accept;
    logic                sel_ok;
    logic                sel_carry;
    logic                start_fix;
    logic [DATA_W-1:0]   hi_data;
    logic                ptr_carry [NUM_PTR];
    logic [2*DATA_W-1:0] ptr_val   [NUM_PTR];

    assign accept  = op_valid && op_ready_reg;
    assign sel_ok  = 32'(sel) < NUM_PTR;
    // LDH takes its byte from the low lane of din, LDW from the high lane.
    assign hi_data = (op == OP_LDW) ? din[2*DATA_W-1:DATA_W] : din[DATA_W-1:0];

    generate
        for (genvar gi = 0; gi < NUM_PTR; gi++) begin : g_ptr
            logic hit;
            assign hit = accept && (sel == SEL_W'(gi));

            addr_ptr #(
                .DATA_W  (DATA_W),
                .RST_VAL (RST_VAL)
            ) u_ptr (
                .clk     (clk),
                .rst     (rst),
                .ld_lo   (hit && (op == OP_LDL || op == OP_LDW)),
                .ld_hi   (hit && (op == OP_LDH || op == OP_LDW)),
                .lo_data (din[DATA_W-1:0]),
                .hi_data (hi_data),
                .inc     (hit && op == OP_INC),
                .add     (hit && (op == OP_ADD_IDX || op == OP_ADD_REL)),
                .idx     (idx),
                .fix     (state_reg == ST_FIXUP && fix_sel_reg == SEL_W'(gi)),
                .fix_dec (fix_dec_reg),
                .carry   (ptr_carry[gi]),
                .val     (ptr_val[gi])
            );
        end
    endgenerate

    always_comb begin
        sel_carry = 1'b0;
        addr_out  = '0;
        for (int i = 0; i < NUM_PTR; i++) begin
            if (sel == SEL_W'(i))      sel_carry = ptr_carry[i];
            if (addr_sel == SEL_W'(i)) addr_out  = ptr_val[i];
        end
    end

    // Negative relative offsets add as unsigned bytes, so a missing carry means a borrow.
    always_comb begin
        start_fix = 1'b0;
        if (accept && sel_ok) begin
            if (op == OP_ADD_IDX)
                start_fix = sel_carry;
            else if (op == OP_ADD_REL)
                start_fix = idx[DATA_W-1] ? !sel_carry : sel_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            op_ready_reg   <= 1'b1;
            page_cross_reg <= 1'b0;
            fix_sel_reg    <= '0;
            fix_dec_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_fix) begin
                        state_reg      <= ST_FIXUP;
                        op_ready_reg   <= 1'b0;
                        page_cross_reg <= 1'b1;
                        fix_sel_reg    <= sel;
                        fix_dec_reg    <= (op == OP_ADD_REL) && idx[DATA_W-1];
                    end
                end
                ST_FIXUP: begin
                    state_reg      <= ST_IDLE;
                    op_ready_reg   <= 1'b1;
                    page_cross_reg <= 1'b0;
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    op_ready_reg   <= 1'b1;
                    page_cross_reg <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready   = op_ready_reg;
    assign page_cross = page_cross_reg;

endmodule
